// File: rtl/mips_pkg.sv
// Shared MIPS datapath types and constants for the iterative multiply/divide unit.
package mips_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } md_state_t;

  localparam int         MD_ITERS = 32;
  localparam logic [4:0] MD_LAST  = 5'(MD_ITERS - 1);

endpackage

// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU: shift-add multiply and restoring divide,
// one bit per cycle, with a one-cycle done strobe for the HI/LO write.
module mult_div_unit
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero,
  output md_state_t   dbg_state
);

  // Handshake: start is sampled on the rising edge only in IDLE or DONE (and not
  // while a divide-by-zero result is pending); done is a one-cycle strobe that
  // coincides with hi/lo/div_by_zero carrying the new result.

  md_state_t   state_q, state_d;
  md_op_t      op_q, op_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;     // multiply: upper accumulator; divide: partial remainder
  logic [31:0] work_q, work_d;   // multiply: multiplier shifter; divide: dividend/quotient
  logic [31:0] opb_q, opb_d;     // multiplicand or divisor magnitude; raw a on divide-by-zero
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic        dz_pend_q, dz_pend_d;
  logic        dz_q, dz_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

  md_op_t      op_in;
  logic        in_signed;
  logic        in_div;
  logic        q_div;
  logic        accept;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic [31:0] iter_rem;
  logic [31:0] iter_work;
  logic [63:0] prod;
  logic [63:0] prod_fix;

  always_comb begin
    op_in     = md_op_t'(op);
    in_signed = (op_in == MD_MULT) || (op_in == MD_DIV);
    in_div    = (op_in == MD_DIV) || (op_in == MD_DIVU);
    q_div     = (op_q == MD_DIV) || (op_q == MD_DIVU);
    accept    = start && !dz_pend_q && ((state_q == IDLE) || (state_q == DONE));

    mul_sum   = {1'b0, rem_q} + (work_q[0] ? {1'b0, opb_q} : 33'd0);
    div_shift = {rem_q, work_q[31]};
    div_diff  = div_shift - {1'b0, opb_q};

    if (q_div) begin
      if (!div_diff[32]) begin
        iter_rem  = div_diff[31:0];
        iter_work = {work_q[30:0], 1'b1};
      end else begin
        iter_rem  = div_shift[31:0];
        iter_work = {work_q[30:0], 1'b0};
      end
    end else begin
      iter_rem  = mul_sum[32:1];
      iter_work = {mul_sum[0], work_q[31:1]};
    end

    prod     = {iter_rem, iter_work};
    prod_fix = neg_res_q ? (~prod + 64'd1) : prod;
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    work_d    = work_q;
    opb_d     = opb_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_pend_d = dz_pend_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      IDLE: begin
        if (dz_pend_q) begin
          state_d   = DONE;
          dz_pend_d = 1'b0;
          dz_d      = 1'b1;
          hi_d      = opb_q;
          lo_d      = 32'hFFFF_FFFF;
        end
      end
      CALC: begin
        rem_d  = iter_rem;
        work_d = iter_work;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == MD_LAST) begin
          state_d = DONE;
          cnt_d   = 5'd0;
          if (q_div) begin
            hi_d = neg32(iter_rem, neg_rem_q);
            lo_d = neg32(iter_work, neg_res_q);
          end else begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A divide by zero skips CALC; the result is posted from IDLE one cycle later.
    if (accept) begin
      op_d      = op_in;
      cnt_d     = 5'd0;
      dz_d      = 1'b0;
      neg_res_d = in_signed && (a[31] ^ b[31]);
      neg_rem_d = in_signed && a[31];
      rem_d     = 32'd0;
      if (in_div && (b == 32'd0)) begin
        state_d   = IDLE;
        dz_pend_d = 1'b1;
        opb_d     = a;
      end else begin
        state_d = CALC;
        if (in_div) begin
          work_d = mag32(a, in_signed);
          opb_d  = mag32(b, in_signed);
        end else begin
          work_d = mag32(b, in_signed);
          opb_d  = mag32(a, in_signed);
        end
      end
    end

    busy_d = (state_d == CALC);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= MD_MULT;
      cnt_q     <= 5'd0;
      rem_q     <= 32'd0;
      work_q    <= 32'd0;
      opb_q     <= 32'd0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_pend_q <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      work_q    <= work_d;
      opb_q     <= opb_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_pend_q <= dz_pend_d;
      dz_q      <= dz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dz_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed scoreboard bench for mult_div_unit: driver pushes expected results,
// a negedge monitor pops and compares them whenever done is seen.
module tb_mult_div_unit;
  import mips_pkg::*;

  localparam int W = 65;  // {hi, lo, div_by_zero}

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;
  md_state_t   dbg_state;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  int           n_cmp;
  int           n_fail;
  int           cyc;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs[12];

  mult_div_unit dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, expv);
    end
  endtask

  // driver: call at a negedge; start is sampled on the following rising edge
  task automatic issue(input logic [1:0] o, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                       input int lat);
    start = 1'b1;
    op    = o;
    a     = ia;
    b     = ib;
    exp_q.push_back({ehi, elo, edz});
    exp_cyc_q.push_back(cyc + lat + 1);
    @(negedge clk);
    start = 1'b0;
    a     = $urandom();
    b     = $urandom();
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: got %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    int           ec;
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, required no result pending", cyc);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        chk("hi", {32'd0, hi}, {32'd0, e[64:33]});
        chk("lo", {32'd0, lo}, {32'd0, e[32:1]});
        chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, e[0]});
        chk("done_cycle", 64'(cyc), 64'(ec));
      end
    end
  end

  initial begin
    vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
    vecs[3]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[4]  = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[5]  = '{2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1};
    vecs[6]  = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[7]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[8]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[9]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[10] = '{2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
    vecs[11] = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};

    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    start  = 1'b0;
    op     = 2'b00;
    a      = 32'd0;
    b      = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_hi", {32'd0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    chk("reset_state", {62'd0, dbg_state}, {62'd0, IDLE});
    reset = 1'b0;
    @(negedge clk);

    // directed vectors
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz,
            vecs[i].dz ? 1 : 32);
      if (vecs[i].dz) begin
        chk("dz_no_early_done", {63'd0, done}, 64'd0);
        chk("dz_not_busy", {63'd0, busy}, 64'd0);
      end else begin
        chk("busy_after_start", {63'd0, busy}, 64'd1);
      end
      if (i == 6) chk("dz_cleared_on_start", {63'd0, div_by_zero}, 64'd0);
      wait_idle();
      if (vecs[i].dz) begin
        repeat (3) @(negedge clk);
        chk("dz_held", {63'd0, div_by_zero}, 64'd1);
      end
      @(negedge clk);
      chk("idle_not_busy", {63'd0, busy}, 64'd0);
    end

    // start during CALC is ignored
    @(negedge clk);
    issue(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 32);
    repeat (9) @(negedge clk);
    start = 1'b1;
    op    = 2'b11;
    a     = 32'd1;
    b     = 32'd0;
    @(negedge clk);
    start = 1'b0;
    chk("busy_ignores_start", {63'd0, busy}, 64'd1);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("ignored_start_no_dz", {63'd0, div_by_zero}, 64'd0);

    // back-to-back: start during the DONE cycle
    @(negedge clk);
    issue(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 32);
    for (int k = 0; k < 60 && !done; k++) @(negedge clk);
    chk("b2b_first_done", {63'd0, done}, 64'd1);
    issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 32);
    chk("b2b_done_drops", {63'd0, done}, 64'd0);
    chk("b2b_busy_rises", {63'd0, busy}, 64'd1);
    wait_idle();
    repeat (2) @(negedge clk);

    // asynchronous reset mid-CALC
    issue(2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 32);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    exp_cyc_q.delete();
    #1;
    chk("midreset_busy", {63'd0, busy}, 64'd0);
    chk("midreset_done", {63'd0, done}, 64'd0);
    chk("midreset_hi", {32'd0, hi}, 64'd0);
    chk("midreset_lo", {32'd0, lo}, 64'd0);
    chk("midreset_dz", {63'd0, div_by_zero}, 64'd0);
    chk("midreset_state", {62'd0, dbg_state}, {62'd0, IDLE});
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 32);
    wait_idle();

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
